// File: rtl/seg_scan_tx.sv
// seg_scan_tx: 8-digit 7-segment display-bus transmitter.
//
// Takes an 8-glyph frame over a valid/ready handshake into a shadow buffer. The frame
// becomes active only when the scan wraps from digit 7 to digit 0, so a frame never tears.
// The active frame is time-multiplexed onto the digits, with per-digit decimal point and
// blink.
//
// Ports
//   clk          system clock
//   rst          synchronous, active-high reset
//   enable       1 = scan; 0 = bus dark, scanner parked at digit 0
//   frame_valid  a frame is offered on glyphs/dp_mask/blink_mask
//   frame_ready  shadow buffer empty; frame taken when valid & ready
//   glyphs       digit k glyph code at [5k+4:5k]; digit 0 is leftmost
//   dp_mask      bit k lights the decimal point of digit k
//   blink_mask   bit k makes digit k blink
//   dig_display  one-hot digit select, active-high
//   seg_code_1   segments {dp,g,f,e,d,c,b,a} for digits 0-3
//   seg_code_2   segments for digits 4-7
//   frame_done   1-cycle pulse when the scan wraps from digit 7 to 0
module seg_scan_tx #(
   parameter int unsigned SCAN_DIV    = 100000,
   parameter int unsigned BLINK_SLOTS = 200
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        enable,
   input  logic        frame_valid,
   output logic        frame_ready,
   input  logic [39:0] glyphs,
   input  logic [7:0]  dp_mask,
   input  logic [7:0]  blink_mask,
   output logic [7:0]  dig_display,
   output logic [7:0]  seg_code_1,
   output logic [7:0]  seg_code_2,
   output logic        frame_done
);

   localparam int unsigned DivW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BlinkW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
   localparam logic [DivW-1:0]   DivMax   = DivW'(SCAN_DIV - 1);
   localparam logic [BlinkW-1:0] BlinkMax = BlinkW'(BLINK_SLOTS - 1);
   localparam logic [39:0]       BlankFrame = {8{5'h10}};

   function automatic logic [6:0] glyph_segs(input logic [4:0] code);
      logic [6:0] s;
      case (code)
         5'h00: s = 7'h3F;
         5'h01: s = 7'h06;
         5'h02: s = 7'h5B;
         5'h03: s = 7'h4F;
         5'h04: s = 7'h66;
         5'h05: s = 7'h6D;
         5'h06: s = 7'h7D;
         5'h07: s = 7'h07;
         5'h08: s = 7'h7F;
         5'h09: s = 7'h6F;
         5'h0A: s = 7'h77;
         5'h0B: s = 7'h7C;
         5'h0C: s = 7'h39;
         5'h0D: s = 7'h5E;
         5'h0E: s = 7'h79;
         5'h0F: s = 7'h71;
         5'h11: s = 7'h40;
         5'h12: s = 7'h38;
         5'h13: s = 7'h73;
         5'h14: s = 7'h50;
         5'h15: s = 7'h54;
         5'h16: s = 7'h5C;
         5'h17: s = 7'h3E;
         5'h18: s = 7'h76;
         5'h19: s = 7'h6E;
         default: s = 7'h00;  // blank (10) and unused codes 1A-1F
      endcase
      return s;
   endfunction

   logic [DivW-1:0]   div_q, div_d;
   logic [2:0]        slot_q, slot_d;
   logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
   logic              blink_phase_q, blink_phase_d;

   logic              shadow_full_q, shadow_full_d;
   logic [39:0]       shadow_glyphs_q, shadow_glyphs_d;
   logic [7:0]        shadow_dp_q, shadow_dp_d;
   logic [7:0]        shadow_blink_q, shadow_blink_d;
   logic [39:0]       active_glyphs_q, active_glyphs_d;
   logic [7:0]        active_dp_q, active_dp_d;
   logic [7:0]        active_blink_q, active_blink_d;

   logic [7:0]        dig_q, dig_d;
   logic [7:0]        seg1_q, seg1_d;
   logic [7:0]        seg2_q, seg2_d;
   logic              done_q, done_d;

   logic              slot_tick, wrap, accept, commit;
   logic [4:0]        cur_glyph;
   logic [7:0]        cur_seg;

   always_comb begin
      div_d           = div_q;
      slot_d          = slot_q;
      blink_cnt_d     = blink_cnt_q;
      blink_phase_d   = blink_phase_q;
      shadow_full_d   = shadow_full_q;
      shadow_glyphs_d = shadow_glyphs_q;
      shadow_dp_d     = shadow_dp_q;
      shadow_blink_d  = shadow_blink_q;
      active_glyphs_d = active_glyphs_q;
      active_dp_d     = active_dp_q;
      active_blink_d  = active_blink_q;

      slot_tick = enable && (div_q == DivMax);
      wrap      = slot_tick && (slot_q == 3'd7);
      accept    = frame_valid && !shadow_full_q;
      // While dark there is no frame to tear, so a pending frame goes live at once.
      commit    = shadow_full_q && (wrap || !enable);

      if (!enable) begin
         div_d         = '0;
         slot_d        = '0;
         blink_cnt_d   = '0;
         blink_phase_d = 1'b0;
      end else if (slot_tick) begin
         div_d  = '0;
         slot_d = slot_q + 3'd1;
         if (blink_cnt_q == BlinkMax) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BlinkW'(1);
         end
      end else begin
         div_d = div_q + DivW'(1);
      end

      // accept and commit are exclusive: one needs the shadow empty, the other full.
      if (accept) begin
         shadow_full_d   = 1'b1;
         shadow_glyphs_d = glyphs;
         shadow_dp_d     = dp_mask;
         shadow_blink_d  = blink_mask;
      end else if (commit) begin
         shadow_full_d   = 1'b0;
         active_glyphs_d = shadow_glyphs_q;
         active_dp_d     = shadow_dp_q;
         active_blink_d  = shadow_blink_q;
      end

      cur_glyph = active_glyphs_q[{3'b000, slot_q} * 6'd5 +: 5];
      cur_seg   = {active_dp_q[slot_q], glyph_segs(cur_glyph)};
      if (blink_phase_q && active_blink_q[slot_q]) begin
         cur_seg = 8'h00;
      end

      dig_d  = 8'h00;
      seg1_d = 8'h00;
      seg2_d = 8'h00;
      done_d = wrap;
      if (enable) begin
         dig_d = 8'b1 << slot_q;
         if (slot_q[2]) begin
            seg2_d = cur_seg;
         end else begin
            seg1_d = cur_seg;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q           <= '0;
         slot_q          <= '0;
         blink_cnt_q     <= '0;
         blink_phase_q   <= 1'b0;
         shadow_full_q   <= 1'b0;
         shadow_glyphs_q <= BlankFrame;
         shadow_dp_q     <= '0;
         shadow_blink_q  <= '0;
         active_glyphs_q <= BlankFrame;
         active_dp_q     <= '0;
         active_blink_q  <= '0;
         dig_q           <= '0;
         seg1_q          <= '0;
         seg2_q          <= '0;
         done_q          <= 1'b0;
      end else begin
         div_q           <= div_d;
         slot_q          <= slot_d;
         blink_cnt_q     <= blink_cnt_d;
         blink_phase_q   <= blink_phase_d;
         shadow_full_q   <= shadow_full_d;
         shadow_glyphs_q <= shadow_glyphs_d;
         shadow_dp_q     <= shadow_dp_d;
         shadow_blink_q  <= shadow_blink_d;
         active_glyphs_q <= active_glyphs_d;
         active_dp_q     <= active_dp_d;
         active_blink_q  <= active_blink_d;
         dig_q           <= dig_d;
         seg1_q          <= seg1_d;
         seg2_q          <= seg2_d;
         done_q          <= done_d;
      end
   end

   assign frame_ready = !shadow_full_q;
   assign dig_display = dig_q;
   assign seg_code_1  = seg1_q;
   assign seg_code_2  = seg2_q;
   assign frame_done  = done_q;

endmodule
